// File: rtl/twiddle_gen.sv
// Per-lane twiddle generator for the 16-lane multiplier of the 512-point FFT.
// Quarter-wave cosine ROM with quadrant folding; fixed 2-cycle beat latency.
module twiddle_gen #(
    parameter int N     = 512,
    parameter int LANES = 16,
    parameter int TW_W  = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    output logic signed [TW_W-1:0] twf_re_out [0:LANES-1],
    output logic signed [TW_W-1:0] twf_im_out [0:LANES-1],
    output logic                   twf_valid,
    output logic                   twf_sof,
    output logic                   twf_eof,
    output logic                   sync_err
);

    localparam int EW = $clog2(N);
    localparam int F  = N / LANES;
    localparam int CW = $clog2(F);
    localparam int MW = EW - 2;
    localparam int QN = N / 4;

    // round(128*cos(2*pi*m/512)) for m = 0..128, clipped to 127
    localparam logic [7:0] COS_ROM [0:128] = '{
        8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127,
        8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd126, 8'd126, 8'd126,
        8'd126, 8'd125, 8'd125, 8'd125, 8'd124, 8'd124, 8'd123, 8'd123,
        8'd122, 8'd122, 8'd122, 8'd121, 8'd121, 8'd120, 8'd119, 8'd119,
        8'd118, 8'd118, 8'd117, 8'd116, 8'd116, 8'd115, 8'd114, 8'd114,
        8'd113, 8'd112, 8'd111, 8'd111, 8'd110, 8'd109, 8'd108, 8'd107,
        8'd106, 8'd106, 8'd105, 8'd104, 8'd103, 8'd102, 8'd101, 8'd100,
        8'd99,  8'd98,  8'd97,  8'd96,  8'd95,  8'd94,  8'd93,  8'd92,
        8'd91,  8'd89,  8'd88,  8'd87,  8'd86,  8'd85,  8'd84,  8'd82,
        8'd81,  8'd80,  8'd79,  8'd78,  8'd76,  8'd75,  8'd74,  8'd72,
        8'd71,  8'd70,  8'd68,  8'd67,  8'd66,  8'd64,  8'd63,  8'd62,
        8'd60,  8'd59,  8'd58,  8'd56,  8'd55,  8'd53,  8'd52,  8'd50,
        8'd49,  8'd48,  8'd46,  8'd45,  8'd43,  8'd42,  8'd40,  8'd39,
        8'd37,  8'd36,  8'd34,  8'd33,  8'd31,  8'd30,  8'd28,  8'd27,
        8'd25,  8'd23,  8'd22,  8'd20,  8'd19,  8'd17,  8'd16,  8'd14,
        8'd13,  8'd11,  8'd9,   8'd8,   8'd6,   8'd5,   8'd3,   8'd2,
        8'd0
    };

    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;
    logic          sync_err_q, sync_err_d;
    logic [CW-1:0] c_sel;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_sof_q, s1_sof_d;
    logic [CW-1:0] s1_c_q, s1_c_d;
    logic [EW-1:0] s1_e_q     [0:LANES-1];
    logic [EW-1:0] s1_e_d     [0:LANES-1];
    logic [MW:0]   s1_idx_b_q [0:LANES-1];
    logic [MW:0]   s1_idx_b_d [0:LANES-1];

    logic                   twf_valid_q, twf_valid_d;
    logic                   twf_sof_q, twf_sof_d;
    logic                   twf_eof_q, twf_eof_d;
    logic signed [TW_W-1:0] re_q [0:LANES-1];
    logic signed [TW_W-1:0] re_d [0:LANES-1];
    logic signed [TW_W-1:0] im_q [0:LANES-1];
    logic signed [TW_W-1:0] im_d [0:LANES-1];

    // first_q marks the first beat after reset, which must carry in_sof
    always_comb begin
        cnt_d      = cnt_q;
        first_d    = first_q;
        sync_err_d = sync_err_q;
        c_sel      = cnt_q;
        if (in_valid) begin
            first_d = 1'b0;
            if (in_sof) begin
                c_sel = '0;
                cnt_d = CW'(1);
                if (cnt_q != '0) sync_err_d = 1'b1;
            end else begin
                c_sel = cnt_q;
                cnt_d = cnt_q + CW'(1);
                if (first_q) sync_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        s1_valid_d = in_valid;
        s1_sof_d   = s1_sof_q;
        s1_c_d     = s1_c_q;
        s1_e_d     = s1_e_q;
        s1_idx_b_d = s1_idx_b_q;
        if (in_valid) begin
            s1_sof_d = in_sof;
            s1_c_d   = c_sel;
            for (int i = 0; i < LANES; i++) begin
                s1_e_d[i]     = EW'(32'(c_sel) * i);
                s1_idx_b_d[i] = (MW+1)'(QN) - {1'b0, s1_e_d[i][MW-1:0]};
            end
        end
    end

    // q0..q3 fold: re = cos, im = -sin
    always_comb begin : stage2_comb
        logic signed [TW_W-1:0] pa;
        logic signed [TW_W-1:0] pb;
        pa          = '0;
        pb          = '0;
        re_d        = re_q;
        im_d        = im_q;
        twf_valid_d = s1_valid_q;
        twf_sof_d   = s1_valid_q & s1_sof_q;
        twf_eof_d   = s1_valid_q & (s1_c_q == CW'(F-1));
        if (s1_valid_q) begin
            for (int i = 0; i < LANES; i++) begin
                pa = signed'(TW_W'(COS_ROM[{1'b0, s1_e_q[i][MW-1:0]}]));
                pb = signed'(TW_W'(COS_ROM[s1_idx_b_q[i]]));
                case (s1_e_q[i][EW-1 -: 2])
                    2'd0: begin re_d[i] = pa;  im_d[i] = -pb; end
                    2'd1: begin re_d[i] = -pb; im_d[i] = -pa; end
                    2'd2: begin re_d[i] = -pa; im_d[i] = pb;  end
                    default: begin re_d[i] = pb; im_d[i] = pa; end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            first_q     <= 1'b1;
            sync_err_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_c_q      <= '0;
            twf_valid_q <= 1'b0;
            twf_sof_q   <= 1'b0;
            twf_eof_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_e_q[i]     <= '0;
                s1_idx_b_q[i] <= '0;
                re_q[i]       <= '0;
                im_q[i]       <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            sync_err_q  <= sync_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_sof_q    <= s1_sof_d;
            s1_c_q      <= s1_c_d;
            s1_e_q      <= s1_e_d;
            s1_idx_b_q  <= s1_idx_b_d;
            twf_valid_q <= twf_valid_d;
            twf_sof_q   <= twf_sof_d;
            twf_eof_q   <= twf_eof_d;
            re_q        <= re_d;
            im_q        <= im_d;
        end
    end

    assign twf_re_out = re_q;
    assign twf_im_out = im_q;
    assign twf_valid  = twf_valid_q;
    assign twf_sof    = twf_sof_q;
    assign twf_eof    = twf_eof_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen: beat sequencing, bubbles, sync errors, async reset.
// Twiddle expectations come from a cosine model plus hand-computed lane constants.
module tb_twiddle_gen;

    localparam int LANES = 16;
    localparam int F     = 32;
    localparam real PI   = 3.14159265358979;

    logic              clk, rst, in_valid, in_sof;
    logic signed [8:0] twf_re_out [0:LANES-1];
    logic signed [8:0] twf_im_out [0:LANES-1];
    logic              twf_valid, twf_sof, twf_eof, sync_err;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt, s1c, s2c;
    bit m_first, m_err, s1v, s1s, s2v, s2s;
    int exp_re [LANES];
    int exp_im [LANES];

    twiddle_gen #(.N(512), .LANES(LANES), .TW_W(9)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .twf_re_out(twf_re_out), .twf_im_out(twf_im_out),
        .twf_valid(twf_valid), .twf_sof(twf_sof), .twf_eof(twf_eof),
        .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cref(input int m);
        real x;
        int  r;
        x = 128.0 * $cos(2.0 * PI * real'(m) / 512.0);
        r = $rtoi(x + 0.5);
        if (r > 127) r = 127;
        return r;
    endfunction

    task automatic tw_ref(input int e, output int re, output int im);
        int q, m, ca, cb, cs, sn;
        q  = e / 128;
        m  = e % 128;
        ca = cref(m);
        cb = cref(128 - m);
        case (q)
            0:       begin cs = ca;  sn = cb;  end
            1:       begin cs = -cb; sn = ca;  end
            2:       begin cs = -ca; sn = -cb; end
            default: begin cs = cb;  sn = -ca; end
        endcase
        re = cs;
        im = -sn;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_first = 1'b1; m_err = 1'b0;
        s1v = 1'b0; s1s = 1'b0; s1c = 0;
        s2v = 1'b0; s2s = 1'b0; s2c = 0;
        for (int l = 0; l < LANES; l++) begin
            exp_re[l] = 0;
            exp_im[l] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, int'(twf_valid), int'(s2v));
        chk({tag, "_sof"}, int'(twf_sof), int'(s2v & s2s));
        chk({tag, "_eof"}, int'(twf_eof), int'(s2v && s2c == F-1));
        chk({tag, "_sync_err"}, int'(sync_err), int'(m_err));
        for (int l = 0; l < LANES; l++) begin
            chk($sformatf("%s_re%0d", tag, l), int'(twf_re_out[l]), exp_re[l]);
            chk($sformatf("%s_im%0d", tag, l), int'(twf_im_out[l]), exp_im[l]);
        end
    endtask

    // one clock with the given inputs; model advances and all outputs are checked
    task automatic cyc(input bit v, input bit s);
        int c;
        in_valid = v;
        in_sof   = s;
        @(posedge clk);
        #1;
        if (s1v)
            for (int l = 0; l < LANES; l++) tw_ref((s1c * l) % 512, exp_re[l], exp_im[l]);
        s2v = s1v; s2s = s1s; s2c = s1c;
        if (v) begin
            if (s) begin
                if (m_cnt != 0) m_err = 1'b1;
                c = 0;
            end else begin
                if (m_first) m_err = 1'b1;
                c = m_cnt;
            end
            m_cnt   = (c + 1) % F;
            m_first = 1'b0;
            s1c     = c;
            s1s     = s;
        end
        s1v = v;
        check_all("cyc");
    endtask

    // hand-computed lane values for the beat currently on the outputs
    task automatic spot(input int c);
        chk($sformatf("c%0d_l0_re", c), int'(twf_re_out[0]), 127);
        chk($sformatf("c%0d_l0_im", c), int'(twf_im_out[0]), 0);
        case (c)
            8: begin
                chk("c8_l8_re", int'(twf_re_out[8]), 91);
                chk("c8_l8_im", int'(twf_im_out[8]), -91);
            end
            16: begin
                chk("c16_l8_re", int'(twf_re_out[8]), 0);
                chk("c16_l8_im", int'(twf_im_out[8]), -127);
                chk("c16_l15_re", int'(twf_re_out[15]), -126);
                chk("c16_l15_im", int'(twf_im_out[15]), -25);
            end
            24: begin
                chk("c24_l8_re", int'(twf_re_out[8]), -91);
                chk("c24_l8_im", int'(twf_im_out[8]), -91);
            end
            31: begin
                chk("c31_l15_re", int'(twf_re_out[15]), 107);
                chk("c31_l15_im", int'(twf_im_out[15]), 70);
            end
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("in_reset");
        rst = 1'b0;
        check_all("reset_state");

        // full frame, then flush
        for (int b = 0; b < F; b++) begin
            cyc(1'b1, b == 0);
            if (b >= 1) spot(b - 1);
        end
        cyc(1'b0, 1'b0);
        spot(31);
        cyc(1'b0, 1'b0);

        // 3-cycle stall after c=5
        for (int b = 0; b < 6; b++) cyc(1'b1, b == 0);
        repeat (3) cyc(1'b0, 1'b0);
        for (int b = 6; b < F; b++) begin
            cyc(1'b1, 1'b0);
            if (b >= 7) spot(b - 1);
        end
        repeat (2) cyc(1'b0, 1'b0);
        chk("stall_no_err", int'(sync_err), 0);

        // restart mid-frame at c=10
        for (int b = 0; b < 10; b++) cyc(1'b1, b == 0);
        cyc(1'b1, 1'b1);
        chk("restart_err_set", int'(sync_err), 1);
        for (int b = 1; b < F; b++) cyc(1'b1, 1'b0);
        for (int b = 0; b < F; b++) cyc(1'b1, b == 0);
        repeat (2) cyc(1'b0, 1'b0);
        chk("err_sticky", int'(sync_err), 1);

        // asynchronous reset between clock edges, mid-frame
        cyc(1'b1, 1'b1);
        for (int b = 1; b < 7; b++) cyc(1'b1, 1'b0);
        #3 rst = 1'b1;
        in_valid = 1'b0; in_sof = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_re8", int'(twf_re_out[8]), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all("rst_release");

        // clean frames back-to-back after reset
        for (int b = 0; b < F; b++) begin
            cyc(1'b1, b == 0);
            if (b >= 1) spot(b - 1);
        end
        for (int b = 0; b < F; b++) cyc(1'b1, b == 0);
        repeat (2) cyc(1'b0, 1'b0);
        chk("b2b_no_err", int'(sync_err), 0);

        // first beat after reset without in_sof
        #3 rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0);
        chk("no_sof_first_err", int'(sync_err), 1);
        cyc(1'b0, 1'b0);
        spot(0);
        chk("no_sof_first_valid", int'(twf_valid), 1);
        cyc(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
- Produces the per-lane twiddle factors consumed by the 16-lane complex twiddle multiplier in the 512-point FFT datapath.
- Tracks the input beat position within each frame: one frame is N/LANES = 32 valid beats.
- For every valid beat, emits LANES signed Q1.7 (re, im) twiddle pairs.
- Values come from a quarter-wave cosine ROM with quadrant folding; the output is pipelined with a fixed 2-cycle latency.

Parameters:
N, 512, FFT length (power of 2); exponent width log2(N) = 9.
LANES, 16, lanes per beat; beats per frame F = N/LANES = 32.
TW_W, 9, twiddle word width, signed Q1.7.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  data beat present this cycle.
in_sof  input  1  first beat of a frame; qualified by in_valid.
twf_re_out[0:LANES-1]  output  TW_W signed  twiddle real part per lane.
twf_im_out[0:LANES-1]  output  TW_W signed  twiddle imaginary part per lane.
twf_valid  output  1  twiddles valid; this is in_valid delayed 2 cycles.
twf_sof  output  1  first beat of a frame, delayed 2 cycles.
twf_eof  output  1  beat index c = F-1, delayed 2 cycles.
sync_err  output  1  sticky frame-sync error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - all twf_re_out/twf_im_out = 0;
  - twf_valid, twf_sof, twf_eof, sync_err = 0;
  - beat counter cnt = 0;
  - pipeline valid bits = 0.
- Reset asserted mid-frame discards all in-flight beats. Nothing is emitted until the next input beat plus 2 cycles.
- Beat index c, selected on in_valid:
  - in_sof = 1: c = 0, cnt_next = 1.
  - in_sof = 0: c = cnt, cnt_next = (cnt + 1) mod F.
- in_valid = 0: cnt holds and in_sof is ignored.
- Wrap: after beat c = F-1, cnt returns to 0. A beat arriving at cnt = 0 without in_sof is still treated as c = 0.
- sync_err is set and stays set until rst when either:
  - in_valid & in_sof & cnt != 0 (restart mid-frame; the counter still restarts at c = 0), or
  - in_valid & !in_sof & cnt == 0 on the first beat after reset.
- Exponent: e_i = (c * i) mod N for lane i. This implements the 32x16 decomposition twiddle W_N^(n2*k1).
- Twiddle definition: W = cos(2*pi*e/N) - j*sin(2*pi*e/N).
- ROM C[m], m = 0..N/4 (129 entries), unsigned 8-bit:
  - C[m] = round(128*cos(2*pi*m/N)), clipped to 127;
  - anchor values: C[0] = 127, C[64] = 91, C[128] = 0.
- Quadrant fold, with q = e[8:7] and m = e[6:0]:
  - q0: cos = C[m], sin = C[128-m].
  - q1: cos = -C[128-m], sin = C[m].
  - q2: cos = -C[m], sin = -C[128-m].
  - q3: cos = C[128-m], sin = -C[m].
- Outputs: twf_re = cos, twf_im = -sin, sign-extended to TW_W. The magnitude of every value is at most 127; -128 never occurs.
- Pipeline (latency exactly 2 cycles from an in_valid beat to twf_valid):
  - Stage 1 registers c, the LANES exponents, q and the folded ROM indices.
  - Stage 2 registers the ROM outputs after sign/quadrant application, plus twf_valid/sof/eof.
  - The companion data path delays its samples by the same 2 cycles.
- Bubbles: in_valid low for k cycles gives twf_valid low for k cycles, 2 cycles later. twf_re/im hold their last values during a bubble.
- Back-to-back frames: an in_sof on the beat right after c = F-1 is legal with no gap. sync_err does not set.
- No backpressure: every in_valid beat is emitted 2 cycles later.

Test Plan:
1. Reset, then in_valid=1 with in_sof on the first beat, for 32 beats -> twf_valid high in cycles 2..33. twf_sof only on the first output beat, twf_eof only on the 32nd. Lane 0 = (127, 0) on every beat.
2. Beat c=8 -> lane 8 (e=64) = (91, -91); lane 16/… n/a. Beat c=16 -> lane 8 (e=128) = (0, -127). Beat c=24 -> lane 8 (e=192) = (-91, -91).
3. Exponent folding checks:
   - Beat c=16, lane 15: e=240, q1, m=112 -> re = -C[16], im = -C[112].
   - Beat c=31, lane 15: e=465 mod 512 = 465, q3, m=81 -> re = C[47], im = +C[81].
   - Beat c=16, lane 8 -> e=128 -> (0, -127).
4. Stall: in_valid low for 3 cycles after beat c=5 -> no twf_valid for those 3 cycles, outputs held, cnt resumes at c=6. Frame still ends with twf_eof on the 32nd valid beat.
5. in_sof at c=10 mid-frame -> counter restarts at c=0, twf_sof asserted 2 cycles later, sync_err=1 and remains 1 across subsequent frames until rst.
6. rst asserted asynchronously mid-frame (between clock edges) -> all outputs 0 immediately with no clock. After release, a frame beginning with in_sof produces correct c=0 twiddles and sync_err stays 0.
